// File: rtl/tran_dir_arbiter.sv
// Direction arbiter for a shared bidirectional pass-switch net: grants one side at a time,
// inserts a break-before-make turnaround, and bounds the hold time while the other side waits.
module tran_dir_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic owner,
    output logic preempt
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam int TW = $clog2(TURN_CYCLES) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    generate
        if (TURN_CYCLES < 1 || MAX_HOLD < 2) begin : g_param_check
            $error("tran_dir_arbiter: TURN_CYCLES must be >= 1 and MAX_HOLD >= 2");
        end
    endgenerate

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] turn_cnt;
    logic          owner_nxt;
    logic          preempt_nxt;

    function automatic logic [HW-1:0] sat_inc_hold(input logic [HW-1:0] v);
        return (v == HOLD_LAST) ? v : v + HW'(1);
    endfunction

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that did not hold the net last wins.
                if (req_a && req_b) begin
                    state_nxt = owner ? GNT_A : GNT_B;
                    owner_nxt = ~owner;
                end else if (req_a) begin
                    state_nxt = GNT_A;
                    owner_nxt = 1'b0;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                    owner_nxt = 1'b1;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    state_nxt = TURN;
                end else if (req_b && hold_cnt == HOLD_LAST) begin
                    state_nxt   = TURN;
                    preempt_nxt = 1'b1;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    state_nxt = TURN;
                end else if (req_a && hold_cnt == HOLD_LAST) begin
                    state_nxt   = TURN;
                    preempt_nxt = 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b1;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= ((state == GNT_A || state == GNT_B) && state_nxt == state)
                        ? sat_inc_hold(hold_cnt) : '0;
            turn_cnt <= (state == TURN && state_nxt == TURN) ? turn_cnt + TW'(1) : '0;
            gnt_a    <= (state_nxt == GNT_A);
            gnt_b    <= (state_nxt == GNT_B);
            busy     <= (state_nxt != IDLE);
            owner    <= owner_nxt;
            preempt  <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_tran_dir_arbiter.sv
// Directed bench for tran_dir_arbiter (TURN_CYCLES=2, MAX_HOLD=4) with a random soak
// under a continuous exclusivity / turnaround-gap monitor.
module tb_tran_dir_arbiter;

    localparam int TC = 2;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic gnt_a, gnt_b, busy, owner, preempt;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    tran_dir_arbiter #(.TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .busy   (busy),
        .owner  (owner),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Invariant monitor: grants exclusive, and every rise is preceded by at least
    // TC+1 cycles with both grants low since the last fall (reset excepted).
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int   gap    = 100;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("excl", {31'd0, gnt_a & gnt_b}, 32'd0);
            if ((gnt_a && !prev_a) || (gnt_b && !prev_b))
                chk("turn_gap", {31'd0, gap >= TC + 1}, 32'd1);
            if (preempt)
                chk("preempt_fall", {31'd0, (prev_a | prev_b) & ~(gnt_a | gnt_b)}, 32'd1);
        end
        if (rst) gap = 100;
        else if (gnt_a || gnt_b) gap = 0;
        else if (gap < 100) gap++;
        prev_a = gnt_a;
        prev_b = gnt_b;
    end

    initial begin
        int n;
        // 1: reset with both requests high
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
        tick();
        tick();
        chk("t1_rst_gnt_a", gnt_a, 0);
        chk("t1_rst_gnt_b", gnt_b, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_preempt", preempt, 0);
        chk("t1_rst_owner", owner, 1);
        mon_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("t1_gnt_a", gnt_a, 1);
        chk("t1_gnt_b", gnt_b, 0);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);

        // 2: single A transfer, req high cycles 0-5
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            req_a = (c <= 5);
            tick();
            n = c + 1;
            chk("t2_gnt_a", gnt_a, (n >= 1 && n <= 6));
            chk("t2_busy", busy, (n <= 8));
            chk("t2_preempt", preempt, 0);
        end

        // 3: A held, B arrives at cycle 2 -> timeout preempt
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            req_a = 1'b1;
            req_b = (c >= 2);
            tick();
            n = c + 1;
            chk("t3_gnt_a", gnt_a, (n >= 1 && n <= 4));
            chk("t3_gnt_b", gnt_b, (n >= 8));
            chk("t3_preempt", preempt, (n == 5));
            chk("t3_busy", busy, (n != 7));
            chk("t3_owner", owner, (n >= 8));
        end

        // 4: tie with owner=0 -> B, then alternation
        do_reset();
        req_a = 1'b1;
        tick();
        chk("t4_setup_owner", owner, 0);
        req_a = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_setup_idle", busy, 0);
        for (int r = 0; r < 10; r++) begin
            req_a = 1'b1;
            req_b = 1'b1;
            tick();
            chk("t4_gnt_b", gnt_b, (r % 2 == 0));
            chk("t4_gnt_a", gnt_a, (r % 2 == 1));
            chk("t4_owner", owner, (r % 2 == 0));
            req_a = 1'b0;
            req_b = 1'b0;
            tick();
            tick();
            tick();
            chk("t4_idle", busy, 0);
        end

        // 5: B alone held long -> no timeout
        do_reset();
        for (int c = 0; c <= 41; c++) begin
            req_b = (c <= 39);
            tick();
            n = c + 1;
            chk("t5_gnt_b", gnt_b, (n >= 1 && n <= 40));
            chk("t5_preempt", preempt, 0);
        end

        // 6: reset mid-GNT_B and mid-TURN
        do_reset();
        req_b = 1'b1;
        tick();
        tick();
        chk("t6_pre_gnt_b", gnt_b, 1);
        rst = 1'b1;
        tick();
        chk("t6_g_gnt_a", gnt_a, 0);
        chk("t6_g_gnt_b", gnt_b, 0);
        chk("t6_g_busy", busy, 0);
        chk("t6_g_owner", owner, 1);
        rst = 1'b0;
        req_a = 1'b1;
        req_b = 1'b0;
        tick();
        chk("t6_regrant_a", gnt_a, 1);
        chk("t6_regrant_owner", owner, 0);
        req_a = 1'b0;
        tick();
        chk("t6_in_turn", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_t_gnt_a", gnt_a, 0);
        chk("t6_t_gnt_b", gnt_b, 0);
        chk("t6_t_busy", busy, 0);
        chk("t6_t_owner", owner, 1);
        rst = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        chk("t6_tie_gnt_a", gnt_a, 1);
        chk("t6_tie_gnt_b", gnt_b, 0);

        // Random soak under the invariant monitor
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 7) == 0) req_b = ~req_b;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
